// File: rtl/ahblite_timer_slave.sv
// AHB-Lite down-counting timer peripheral.
// Zero-wait-state slave with prescaler, periodic/one-shot reload and a
// level interrupt. Registers: CTRL, LOAD, VALUE (RO), PRESCALE, STATUS (W1C).
module ahblite_timer_slave #(
  parameter int          PRESCALE_W = 16,
  parameter logic [31:0] LOAD_RESET = 32'hFFFF_FFFF
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic [2:0]  HSIZE,
  input  logic [2:0]  HBURST,
  input  logic [3:0]  HPROT,
  input  logic [31:0] HWDATA,
  input  logic        HREADY,
  output logic        HREADYOUT,
  output logic [1:0]  HRESP,
  output logic [31:0] HRDATA,
  output logic        TIMER_IRQ
);

  localparam logic [2:0] A_CTRL     = 3'd0;
  localparam logic [2:0] A_LOAD     = 3'd1;
  localparam logic [2:0] A_VALUE    = 3'd2;
  localparam logic [2:0] A_PRESCALE = 3'd3;
  localparam logic [2:0] A_STATUS   = 3'd4;

  typedef enum logic {ST_STOPPED, ST_RUNNING} cnt_state_t;

  // Little-endian byte-lane strobe; anything wider than a halfword is a word.
  function automatic logic [3:0] byte_strobe(input logic [2:0] size, input logic [1:0] lo);
    logic [3:0] s;
    case (size)
      3'd0:    s = 4'b0001 << lo;
      3'd1:    s = lo[1] ? 4'b1100 : 4'b0011;
      default: s = 4'b1111;
    endcase
    return s;
  endfunction

  // Replace only the strobed bytes of a register word.
  function automatic logic [31:0] merge_bytes(input logic [31:0] old_w,
                                              input logic [31:0] new_w,
                                              input logic [3:0]  strb);
    logic [31:0] res;
    for (int i = 0; i < 4; i++) begin
      res[8*i +: 8] = strb[i] ? new_w[8*i +: 8] : old_w[8*i +: 8];
    end
    return res;
  endfunction

  // Bus-side state
  logic                  addr_valid;
  logic                  wr_pend;
  logic                  rd_pend;
  logic [2:0]            addr_p1;
  logic [3:0]            strb_p1;

  // Timer registers
  cnt_state_t            state;
  cnt_state_t            state_nxt;
  logic                  ctrl_irqen;
  logic                  ctrl_oneshot;
  logic [31:0]           load_r;
  logic [31:0]           value_r;
  logic [31:0]           value_nxt;
  logic [PRESCALE_W-1:0] prescale_r;
  logic [PRESCALE_W-1:0] pre_wdata;
  logic [PRESCALE_W-1:0] pcnt;
  logic [PRESCALE_W-1:0] pcnt_nxt;
  logic                  status_irq;
  logic                  irq_set;

  // Decoded data-phase actions
  logic                  wr_ctrl;
  logic                  wr_load;
  logic                  wr_pre;
  logic                  clr_stat;
  logic [31:0]           load_wdata;
  logic [31:0]           pre_word;
  logic                  tick;
  logic                  unused_bus;

  assign addr_valid = HSEL & HTRANS[1] & HREADY;
  assign unused_bus = ^{HBURST, HPROT, HADDR[31:5], HTRANS[0]};

  assign HREADYOUT  = 1'b1;
  assign HRESP      = 2'b00;

  assign wr_ctrl    = wr_pend && (addr_p1 == A_CTRL) && strb_p1[0];
  assign wr_load    = wr_pend && (addr_p1 == A_LOAD);
  assign wr_pre     = wr_pend && (addr_p1 == A_PRESCALE);
  assign clr_stat   = wr_pend && (addr_p1 == A_STATUS) && strb_p1[0] && HWDATA[0];
  assign load_wdata = merge_bytes(load_r, HWDATA, strb_p1);
  assign pre_word   = 32'(prescale_r);

  assign tick       = (state == ST_RUNNING) && (pcnt == prescale_r);
  assign TIMER_IRQ  = status_irq & ctrl_irqen;

  // Byte-merge the PRESCALE write word, bit by bit so any PRESCALE_W works.
  always_comb begin
    pre_wdata = prescale_r;
    for (int i = 0; i < PRESCALE_W; i++) begin
      if (strb_p1[i/8]) pre_wdata[i] = HWDATA[i];
    end
  end

  // Address-phase handshake flags; a non-selected cycle ends the data phase.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      wr_pend <= 1'b0;
      rd_pend <= 1'b0;
    end else begin
      wr_pend <= addr_valid & HWRITE;
      rd_pend <= addr_valid & ~HWRITE;
    end
  end

  // ---- address phase -> data phase boundary ----
  // Address and lane strobe are only consumed while a pend flag is set.
  always_ff @(posedge HCLK) begin
    if (addr_valid) begin
      addr_p1 <= HADDR[4:2];
      strb_p1 <= byte_strobe(HSIZE, HADDR[1:0]);
    end
  end

  // Counter/prescaler next state; LOAD and CTRL writes override the tick.
  always_comb begin
    state_nxt = state;
    value_nxt = value_r;
    pcnt_nxt  = pcnt;
    irq_set   = 1'b0;
    case (state)
      ST_STOPPED: pcnt_nxt = '0;
      ST_RUNNING: begin
        pcnt_nxt = tick ? '0 : pcnt + 1'b1;
        if (tick) begin
          if (value_r != 32'd0) begin
            value_nxt = value_r - 32'd1;
          end else begin
            irq_set = 1'b1;
            if (ctrl_oneshot) state_nxt = ST_STOPPED;
            else              value_nxt = load_r;
          end
        end
      end
      default: state_nxt = ST_STOPPED;
    endcase
    if (wr_load) begin
      value_nxt = load_wdata;
      pcnt_nxt  = '0;
      irq_set   = 1'b0;
      state_nxt = state;
    end
    if (wr_ctrl) begin
      state_nxt = HWDATA[0] ? ST_RUNNING : ST_STOPPED;
      if (HWDATA[0] && (state == ST_STOPPED)) pcnt_nxt = '0;
    end
    if (state_nxt == ST_STOPPED) pcnt_nxt = '0;
  end

  // Timer register file; hardware set of STATUS beats a W1C on the same edge.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state        <= ST_STOPPED;
      ctrl_irqen   <= 1'b0;
      ctrl_oneshot <= 1'b0;
      load_r       <= LOAD_RESET;
      value_r      <= LOAD_RESET;
      prescale_r   <= '0;
      pcnt         <= '0;
      status_irq   <= 1'b0;
    end else begin
      state   <= state_nxt;
      value_r <= value_nxt;
      pcnt    <= pcnt_nxt;
      if (wr_ctrl) begin
        ctrl_irqen   <= HWDATA[1];
        ctrl_oneshot <= HWDATA[2];
      end
      if (wr_load) load_r     <= load_wdata;
      if (wr_pre)  prescale_r <= pre_wdata;
      if (irq_set)       status_irq <= 1'b1;
      else if (clr_stat) status_irq <= 1'b0;
    end
  end

  // Read mux, driven only during a read data phase.
  always_comb begin
    HRDATA = 32'd0;
    if (rd_pend) begin
      case (addr_p1)
        A_CTRL:     HRDATA = {29'd0, ctrl_oneshot, ctrl_irqen, state == ST_RUNNING};
        A_LOAD:     HRDATA = load_r;
        A_VALUE:    HRDATA = value_r;
        A_PRESCALE: HRDATA = pre_word;
        A_STATUS:   HRDATA = {31'd0, status_irq};
        default:    HRDATA = 32'd0;
      endcase
    end
  end

endmodule

// File: tb/tb_ahblite_timer_slave.sv
// Scoreboard bench for ahblite_timer_slave: directed scenarios then random
// traffic, checked against a transaction-level model of the timer.
module tb_ahblite_timer_slave;

  localparam int PW = 16;

  logic        HCLK = 1'b0;
  logic        HRESETn;
  logic        HSEL;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [2:0]  HBURST;
  logic [3:0]  HPROT;
  logic [31:0] HWDATA;
  logic        HREADY;
  logic        HREADYOUT;
  logic [1:0]  HRESP;
  logic [31:0] HRDATA;
  logic        TIMER_IRQ;

  always #5 HCLK = ~HCLK;

  ahblite_timer_slave #(.PRESCALE_W(PW), .LOAD_RESET(32'hFFFF_FFFF)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HADDR(HADDR),
    .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST),
    .HPROT(HPROT), .HWDATA(HWDATA), .HREADY(HREADY), .HREADYOUT(HREADYOUT),
    .HRESP(HRESP), .HRDATA(HRDATA), .TIMER_IRQ(TIMER_IRQ)
  );

  // Reference model state
  bit          m_en, m_irqen, m_oneshot, m_status;
  logic [31:0] m_load, m_value;
  logic [PW-1:0] m_pre, m_pcnt;

  int checks = 0;
  int failures = 0;
  logic [31:0] exp_q[$];
  bit          rd_now = 1'b0;

  // Previous transfer, now in its data phase
  bit          p_wr = 1'b0, p_rd = 1'b0;
  logic [31:0] p_addr = '0, p_wdata = '0;
  logic [2:0]  p_size = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_en = 0; m_irqen = 0; m_oneshot = 0; m_status = 0;
    m_load = 32'hFFFF_FFFF; m_value = 32'hFFFF_FFFF;
    m_pre = '0; m_pcnt = '0;
  endtask

  function automatic logic [31:0] m_read(input logic [2:0] r);
    case (r)
      3'd0:    return {29'd0, m_oneshot, m_irqen, m_en};
      3'd1:    return m_load;
      3'd2:    return m_value;
      3'd3:    return 32'(m_pre);
      3'd4:    return {31'd0, m_status};
      default: return 32'd0;
    endcase
  endfunction

  // Lanes covered by an access of 2^size bytes, aligned down to its size.
  function automatic logic [3:0] m_strobe(input logic [2:0] size, input logic [1:0] lo);
    int nbytes, base;
    logic [3:0] s;
    nbytes = (size >= 3'd2) ? 4 : (1 << size);
    base   = int'(lo) & ~(nbytes - 1);
    for (int i = 0; i < 4; i++) s[i] = (i >= base) && (i < base + nbytes);
    return s;
  endfunction

  // One clock edge of the timer: bus write (if any) plus counting.
  task automatic model_step(input bit wr, input logic [31:0] addr,
                            input logic [2:0] size, input logic [31:0] wdata);
    logic [3:0] s;
    logic [2:0] r;
    logic [31:0] merged, n_value;
    logic [PW-1:0] n_pcnt;
    bit tick, set_irq, ld_wr, n_en, n_status;
    s = m_strobe(size, addr[1:0]);
    r = addr[4:2];
    merged = m_read(r);
    for (int i = 0; i < 4; i++) if (s[i]) merged[8*i +: 8] = wdata[8*i +: 8];
    ld_wr = wr && (r == 3'd1);
    tick  = m_en && (m_pcnt == m_pre);
    n_en = m_en; n_value = m_value; n_status = m_status; set_irq = 0;
    if (!m_en) n_pcnt = '0;
    else if (tick) n_pcnt = '0;
    else n_pcnt = m_pcnt + 1'b1;
    if (tick && !ld_wr) begin
      if (m_value != 0) n_value = m_value - 1;
      else begin
        set_irq = 1;
        if (m_oneshot) n_en = 0;
        else n_value = m_load;
      end
    end
    if (wr) begin
      case (r)
        3'd0: if (s[0]) begin
          if (merged[0] && !m_en) n_pcnt = '0;
          n_en = merged[0]; m_irqen = merged[1]; m_oneshot = merged[2];
        end
        3'd1: begin m_load = merged; n_value = merged; n_pcnt = '0; end
        3'd3: m_pre = merged[PW-1:0];
        3'd4: if (s[0] && wdata[0]) n_status = 0;
        default: ;
      endcase
    end
    if (set_irq) n_status = 1;
    if (!n_en) n_pcnt = '0;
    m_en = n_en; m_value = n_value; m_status = n_status; m_pcnt = n_pcnt;
  endtask

  // Monitor: compares every bus-visible output mid-cycle.
  always @(negedge HCLK) begin
    if (HRESETn) begin
      check("hreadyout", {31'd0, HREADYOUT}, 32'd1);
      check("hresp", {30'd0, HRESP}, 32'd0);
      check("timer_irq", {31'd0, TIMER_IRQ}, {31'd0, m_status & m_irqen});
      if (rd_now) begin
        if (exp_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL rd_scoreboard_empty actual=%h expected=none", HRDATA);
        end else begin
          check("hrdata", HRDATA, exp_q.pop_front());
        end
      end else begin
        check("hrdata_idle", HRDATA, 32'd0);
      end
    end
  end

  // One bus cycle: new address phase (or idle) plus the previous data phase.
  task automatic cycle(input bit tx, input bit wr, input logic [31:0] addr,
                       input logic [2:0] size, input logic [31:0] wdata);
    HWDATA = p_wdata;
    rd_now = p_rd;
    if (p_rd) exp_q.push_back(m_read(p_addr[4:2]));
    HBURST = 3'($urandom);
    HPROT  = 4'($urandom);
    if (tx) begin
      HSEL = 1; HREADY = 1; HTRANS = {1'b1, 1'($urandom)};
      HADDR = addr; HWRITE = wr; HSIZE = size;
    end else begin
      HADDR = $urandom; HWRITE = 1'($urandom); HSIZE = 3'($urandom);
      HSEL = 1; HTRANS = 2'b10; HREADY = 1;
      case ((p_wr || p_rd) ? $urandom_range(0, 1) : $urandom_range(0, 2))
        0: HSEL = 0;
        1: HTRANS = {1'b0, 1'($urandom)};
        default: HREADY = 0;
      endcase
    end
    @(posedge HCLK);
    model_step(p_wr, p_addr, p_size, p_wdata);
    p_wr = tx && wr; p_rd = tx && !wr;
    p_addr = addr; p_size = size; p_wdata = wdata;
    #1;
  endtask

  task automatic wr_t(input logic [31:0] a, input logic [2:0] sz, input logic [31:0] d);
    cycle(1, 1, a, sz, d);
  endtask
  task automatic rd_t(input logic [31:0] a);
    cycle(1, 0, a, 3'd2, 32'd0);
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 32'd0, 3'd0, 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    HRESETn = 0; HSEL = 0; HADDR = 0; HTRANS = 0; HWRITE = 0; HSIZE = 0;
    HBURST = 0; HPROT = 0; HWDATA = 0; HREADY = 1;
    model_reset();
    repeat (3) @(posedge HCLK);
    #1 HRESETn = 1;

    // Reset values
    rd_t(32'h00); rd_t(32'h04); rd_t(32'h08); rd_t(32'h0C); rd_t(32'h10);
    idle(2);

    // Periodic mode
    wr_t(32'h04, 3'd2, 32'd3);
    wr_t(32'h0C, 3'd2, 32'd1);
    wr_t(32'h00, 3'd2, 32'd3);
    repeat (10) rd_t(32'h08);
    rd_t(32'h10);
    wr_t(32'h10, 3'd2, 32'd1);
    idle(3);

    // One-shot mode
    wr_t(32'h00, 3'd2, 32'd0);
    wr_t(32'h04, 3'd2, 32'd2);
    wr_t(32'h0C, 3'd2, 32'd0);
    wr_t(32'h10, 3'd2, 32'd1);
    wr_t(32'h00, 3'd2, 32'd7);
    idle(4);
    rd_t(32'h00); rd_t(32'h08); rd_t(32'h10);
    repeat (10) rd_t(32'h08);

    // Byte lanes and sizing, unmapped offset
    wr_t(32'h00, 3'd2, 32'd0);
    wr_t(32'h04, 3'd2, 32'd3);
    wr_t(32'h05, 3'd0, 32'h0000_AB00);
    wr_t(32'h06, 3'd1, 32'h1234_0000);
    rd_t(32'h04); rd_t(32'h08);
    wr_t(32'h18, 3'd2, 32'hFFFF_FFFF);
    rd_t(32'h18); rd_t(32'h00); rd_t(32'h04); rd_t(32'h0C); rd_t(32'h10);

    // Collisions: W1C against reload, LOAD write against zero tick
    wr_t(32'h10, 3'd2, 32'd1);
    wr_t(32'h04, 3'd2, 32'd1);
    wr_t(32'h00, 3'd2, 32'd1);
    idle(1);
    wr_t(32'h10, 3'd2, 32'd1);
    rd_t(32'h10);
    wr_t(32'h04, 3'd2, 32'd9);
    rd_t(32'h08); rd_t(32'h10); rd_t(32'h08);

    // Back-to-back write then read of CTRL
    wr_t(32'h00, 3'd2, 32'd6);
    rd_t(32'h00);
    wr_t(32'h00, 3'd2, 32'd3);
    rd_t(32'h00);

    // Asynchronous reset mid-count
    wr_t(32'h0C, 3'd2, 32'd3);
    wr_t(32'h04, 3'd2, 32'd100);
    wr_t(32'h00, 3'd2, 32'd3);
    idle(6);
    #2 HRESETn = 0;
    #1;
    check("rst_hrdata", HRDATA, 32'd0);
    check("rst_irq", {31'd0, TIMER_IRQ}, 32'd0);
    check("rst_hreadyout", {31'd0, HREADYOUT}, 32'd1);
    model_reset();
    exp_q.delete();
    rd_now = 0; p_wr = 0; p_rd = 0; p_wdata = 0;
    HSEL = 0;
    @(posedge HCLK);
    #1 HRESETn = 1;
    rd_t(32'h00); rd_t(32'h04); rd_t(32'h08); rd_t(32'h0C); rd_t(32'h10);
    idle(1);

    // Randomized traffic
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 9) < 3) begin
        idle(1);
      end else begin
        logic [31:0] a, d;
        a = {27'd0, 3'($urandom_range(0, 7)), 2'($urandom)};
        d = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 12));
        if ($urandom_range(0, 1) == 1) wr_t(a, 3'($urandom_range(0, 3)), d);
        else rd_t(a);
      end
    end
    idle(3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
